axil_regbank_param: RTL and testbench
=====================================

Name: axil_regbank_param

Overview:
- Parametrised AXI4-Lite slave register bank for the eth_10g control path; successor to the fixed 4-register S00_AXI slave.
- Provides NUM_RW read/write control registers with byte strobes and per-register write pulses.
- Provides NUM_RO read-only status registers sampled from fabric inputs.
- Returns SLVERR on out-of-range accesses and on writes to read-only registers. Sits between the AXI interconnect and the MAC/PCS control logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; legal values 32 or 64.
- C_S_AXI_ADDR_WIDTH, 8, byte address width.
- NUM_RW, 12, number of read/write registers, at indices 0..NUM_RW-1.
- NUM_RO, 4, number of read-only registers, at indices NUM_RW..NUM_RW+NUM_RO-1.
- Constraint: NUM_RW+NUM_RO <= 2^(C_S_AXI_ADDR_WIDTH-log2(DW/8)), and NUM_RW >= 1.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
- S_AXI_RDATA  out  DW  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
- ctrl_regs  out  NUM_RW*DW  flattened RW registers; register k occupies [k*DW +: DW]
- ctrl_wr_pulse  out  NUM_RW  one-cycle pulse per successful write
- status_regs  in  NUM_RO*DW  flattened RO values

Behaviour:
- Reset: asynchronous, active low.
  - All outputs return to 0 while S_AXI_ARESETN=0: ctrl_regs, ctrl_wr_pulse, BVALID, BRESP, RVALID, RRESP, RDATA, AWREADY, WREADY, ARREADY.
  - Ready signals rise on the first clock edge after reset release.
  - Reset mid-transaction aborts it; no partial register update.
- Address decode: index = addr >> log2(DW/8); low byte-offset bits are ignored.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1.
    - AW and W both handshake in the same cycle -> commit at that edge -> W_RESP.
    - AW only -> latch address -> W_HAVE_AW.
    - W only -> latch data and strobe -> W_HAVE_W.
  - W_HAVE_AW: WREADY=1, AWREADY=0. W handshake -> commit -> W_RESP.
  - W_HAVE_W: AWREADY=1, WREADY=0. AW handshake -> commit -> W_RESP.
  - W_RESP: BVALID=1, AWREADY=WREADY=0. BREADY=1 -> W_IDLE, with BVALID dropping the next cycle.
- Commit rules:
  - index < NUM_RW: each byte b with WSTRB[b]=1 is written. ctrl_wr_pulse[index]=1 in the cycle after commit. BRESP=OKAY (00).
  - RO index or index >= NUM_RW+NUM_RO: no state change, no pulse, BRESP=SLVERR (10).
  - WSTRB=0 to an RW index: no byte changes, pulse still fires, OKAY.
- Write latency: AW+W in the same cycle -> BVALID high 1 cycle later; ctrl_regs updated 1 cycle later.
- Read FSM states:
  - R_IDLE: ARREADY=1. AR handshake -> capture RDATA/RRESP at that edge -> R_DATA.
  - R_DATA: RVALID=1, ARREADY=0. RDATA/RRESP held stable until RREADY=1 -> R_IDLE.
- Read data:
  - RW index returns the register value.
  - RO index returns status_regs, sampled at the AR edge.
  - Out-of-range returns RDATA=0 with RRESP=SLVERR.
- Read latency: RVALID 1 cycle after AR handshake. Maximum throughput is one read per 2 cycles with RREADY tied high.
- Read and write channels are fully independent.
- Simultaneous write commit and AR to the same register on the same edge: read returns the pre-write value.
- BVALID and RVALID never drop without their ready. Back-pressure is held indefinitely with no lost response.

Test Plan:
- Reset sequence:
  - Write 0x00000001..0x00000004 to addresses 0x00,0x04,0x08,0x0C, then read back -> equal data, all OKAY.
  - Each write produces ctrl_wr_pulse[0..3] for exactly one cycle.
- Strobes: with reg2=0xAABBCCDD, write 0x11223344 with WSTRB=4'b0101 -> read 0xAA22CC44, OKAY.
- Channel ordering:
  - AW issued 3 cycles before W -> single commit, BVALID 1 cycle after the W handshake.
  - Repeat with W before AW -> same result.
- RO and range errors:
  - status_regs[0]=0xDEADBEEF; read 0x30 -> 0xDEADBEEF, OKAY.
  - Write 0x30 -> SLVERR, value unchanged, no pulse.
  - Read/write 0x40 -> SLVERR, RDATA=0.
- Back-pressure: hold BREADY=0 and RREADY=0 for 10 cycles -> BVALID/RVALID and data stable, AWREADY/WREADY/ARREADY stay 0, no second transaction accepted.
- Reset mid-write: assert ARESETN=0 while in W_HAVE_AW -> all outputs 0 immediately; after release, reg0 reads 0.

Source files
------------

// File: rtl/axil_regbank_param.sv
// AXI4-Lite register bank: NUM_RW byte-strobed control registers plus NUM_RO sampled status words.
// B/R responses arrive one cycle after the completing handshake and are held until BREADY/RREADY.
module axil_regbank_param #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int NUM_RW             = 12,
  parameter int NUM_RO             = 4
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0]   ctrl_regs,
  output logic [NUM_RW-1:0]                      ctrl_wr_pulse,
  input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]   status_regs
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int NB       = DW / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int CW       = NUM_RW * DW;
  localparam logic [31:0] N_RW = 32'(NUM_RW);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  wstate_e         wstate_q;
  logic            awready_q, wready_q, bvalid_q;
  logic [1:0]      bresp_q;
  logic [AW-1:0]   awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   wstrb_q;
  logic [CW-1:0]   ctrl_q, ctrl_d;
  logic [NUM_RW-1:0] pulse_q, pulse_d;

  rstate_e         rstate_q;
  logic            arready_q, rvalid_q;
  logic [DW-1:0]   rdata_q, rd_dat;
  logic [1:0]      rresp_q, rd_resp;

  logic            aw_hs, w_hs, ar_hs;
  logic            wr_commit, wr_ok;
  logic [AW-1:0]   c_addr;
  logic [DW-1:0]   c_dat, c_mask;
  logic [NB-1:0]   c_strb;
  logic [31:0]     w_idx, r_idx;
  logic            unused_ok;

  assign aw_hs = S_AXI_AWVALID && awready_q;
  assign w_hs  = S_AXI_WVALID && wready_q;
  assign ar_hs = S_AXI_ARVALID && arready_q;

  // Whichever half arrives last completes the write; the other half comes from its latch.
  always_comb begin
    wr_commit = 1'b0;
    c_addr    = S_AXI_AWADDR;
    c_dat     = S_AXI_WDATA;
    c_strb    = S_AXI_WSTRB;
    case (wstate_q)
      W_IDLE:    wr_commit = aw_hs && w_hs;
      W_HAVE_AW: begin
        wr_commit = w_hs;
        c_addr    = awaddr_q;
      end
      W_HAVE_W:  begin
        wr_commit = aw_hs;
        c_dat     = wdata_q;
        c_strb    = wstrb_q;
      end
      default:   wr_commit = 1'b0;
    endcase
  end

  assign w_idx = 32'(c_addr[AW-1:ADDR_LSB]);
  assign r_idx = 32'(S_AXI_ARADDR[AW-1:ADDR_LSB]);
  assign wr_ok = wr_commit && (w_idx < N_RW);

  always_comb begin
    c_mask = '0;
    for (int b = 0; b < NB; b++) begin
      c_mask[b*8 +: 8] = {8{c_strb[b]}};
    end
    ctrl_d = ctrl_q;
    for (int k = 0; k < NUM_RW; k++) begin
      if (wr_ok && (w_idx == 32'(k))) begin
        ctrl_d[k*DW +: DW] = (ctrl_q[k*DW +: DW] & ~c_mask) | (c_dat & c_mask);
      end
    end
    pulse_d = wr_ok ? (NUM_RW'(1) << w_idx) : '0;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_q  <= '0;
      pulse_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      pulse_q <= pulse_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else if (wr_commit) begin
      wstate_q  <= W_RESP;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b1;
      bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_q  <= S_AXI_AWADDR;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wstate_q  <= W_HAVE_AW;
          end else if (w_hs) begin
            wdata_q   <= S_AXI_WDATA;
            wstrb_q   <= S_AXI_WSTRB;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            wstate_q  <= W_HAVE_W;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Reads see ctrl_q before any same-edge write lands.
  always_comb begin
    rd_dat  = '0;
    rd_resp = RESP_SLVERR;
    for (int k = 0; k < NUM_RW; k++) begin
      if (r_idx == 32'(k)) begin
        rd_dat  = ctrl_q[k*DW +: DW];
        rd_resp = RESP_OKAY;
      end
    end
    for (int j = 0; j < NUM_RO; j++) begin
      if (r_idx == 32'(NUM_RW + j)) begin
        rd_dat  = status_regs[j*DW +: DW];
        rd_resp = RESP_OKAY;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_dat;
            rresp_q   <= rd_resp;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl_regs     = ctrl_q;
  assign ctrl_wr_pulse = pulse_q;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axil_regbank_param.sv
// Randomised bench for axil_regbank_param: a reference register model predicts every response,
// and a negedge monitor pops and compares expectations as the DUT presents B, R and write pulses.
module tb_axil_regbank_param;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NRW = 12;
  localparam int NRO = 4;
  localparam int CW  = NRW * DW;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef logic [CW-1:0] cw_t;
  typedef struct {logic [1:0] resp; cw_t regs;} bexp_t;
  typedef struct {logic [1:0] resp; logic [DW-1:0] dat;} rexp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [AW-1:0] awaddr = '0;
  logic [2:0] awprot = '0;
  logic awvalid = 1'b0;
  logic awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic wvalid = 1'b0;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [2:0] arprot = '0;
  logic arvalid = 1'b0;
  logic arready;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready = 1'b0;
  logic [CW-1:0] ctrl_regs;
  logic [NRW-1:0] ctrl_wr_pulse;
  logic [NRO*DW-1:0] status_regs;

  always #5 clk = ~clk;

  axil_regbank_param #(
    .C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_regs(ctrl_regs), .ctrl_wr_pulse(ctrl_wr_pulse), .status_regs(status_regs)
  );

  logic [DW-1:0] mdl [NRW];
  logic [DW-1:0] stat [NRO];
  for (genvar j = 0; j < NRO; j++) begin : g_stat
    assign status_regs[j*DW +: DW] = stat[j];
  end

  int n_vec = 0, n_bad = 0;
  int b_issued = 0, b_seen = 0, r_issued = 0, r_seen = 0;
  bexp_t bq[$];
  rexp_t rq[$];
  int pq[$];
  bexp_t be;
  rexp_t re;
  int pk;

  task automatic chk(input string nm, input cw_t act, input cw_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected event, expected orderly handshake at %0t", nm, $time);
  endtask

  function automatic cw_t pack_mdl();
    cw_t v;
    for (int k = 0; k < NRW; k++) v[k*DW +: DW] = mdl[k];
    return v;
  endfunction

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a) / (DW / 8);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        b_seen++;
        if (bq.size() == 0) fail_now("b_unexpected");
        else begin
          be = bq.pop_front();
          chk("bresp", cw_t'(bresp), cw_t'(be.resp));
          chk("ctrl_regs", ctrl_regs, be.regs);
        end
      end
      if (rvalid && rready) begin
        r_seen++;
        if (rq.size() == 0) fail_now("r_unexpected");
        else begin
          re = rq.pop_front();
          chk("rdata", cw_t'(rdata), cw_t'(re.dat));
          chk("rresp", cw_t'(rresp), cw_t'(re.resp));
        end
      end
      if (ctrl_wr_pulse != '0) begin
        if (pq.size() == 0) fail_now("wr_pulse_unexpected");
        else begin
          pk = pq.pop_front();
          chk("wr_pulse", cw_t'(ctrl_wr_pulse), cw_t'(1) << pk);
        end
      end
    end
  end

  task automatic wr_issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int awd, input int wd);
    int idx, cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    bexp_t e;
    cw_t onehot;
    idx = idx_of(a);
    onehot = '0;
    if (idx < NRW) begin
      for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
      pq.push_back(idx);
      onehot = cw_t'(1) << idx;
      e.resp = OKAY;
    end else e.resp = SLVERR;
    e.regs = pack_mdl();
    bq.push_back(e);
    b_issued++;
    awaddr = a; wdata = d; wstrb = s;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && (cyc >= awd);
      wvalid  = !w_done && (cyc >= wd);
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      aw_done = aw_done | aw_hs;
      w_done  = w_done | w_hs;
      cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) fail_now("wr_handshake");
    chk("b_latency", cw_t'(bvalid), cw_t'(1'b1));
    chk("commit_regs", ctrl_regs, pack_mdl());
    chk("pulse_latency", cw_t'(ctrl_wr_pulse), onehot);
  endtask

  task automatic wait_b(input int dly);
    int t;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    bready = 1'b1;
    t = 0;
    while (b_seen != b_issued && t < 100) begin @(posedge clk); #1; t++; end
    bready = 1'b0;
    if (b_seen != b_issued) fail_now("b_wait");
  endtask

  task automatic rd_expect(input logic [AW-1:0] a);
    int idx;
    rexp_t e;
    idx = idx_of(a);
    if (idx < NRW) begin e.dat = mdl[idx]; e.resp = OKAY; end
    else if (idx < NRW + NRO) begin e.dat = stat[idx-NRW]; e.resp = OKAY; end
    else begin e.dat = '0; e.resp = SLVERR; end
    rq.push_back(e);
    r_issued++;
  endtask

  task automatic rd_drive(input logic [AW-1:0] a);
    int idx, cyc;
    bit done, hs;
    idx = idx_of(a);
    araddr = a; done = 0; cyc = 0;
    while (!done && cyc < 50) begin
      arvalid = 1'b1;
      @(negedge clk);
      hs = arready;
      @(posedge clk); #1;
      done = hs;
      cyc++;
    end
    arvalid = 1'b0;
    if (!done) fail_now("rd_handshake");
    // Status moves right after the AR edge; the captured word must not follow it.
    if (idx >= NRW && idx < NRW + NRO) stat[idx-NRW] = $urandom();
    chk("r_latency", cw_t'(rvalid), cw_t'(1'b1));
  endtask

  task automatic wait_r(input int dly);
    int t;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    rready = 1'b1;
    t = 0;
    while (r_seen != r_issued && t < 100) begin @(posedge clk); #1; t++; end
    rready = 1'b0;
    if (r_seen != r_issued) fail_now("r_wait");
  endtask

  task automatic rd(input logic [AW-1:0] a, input int dly);
    rd_expect(a);
    rd_drive(a);
    wait_r(dly);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                    input int awd, input int wd, input int dly);
    wr_issue(a, d, s, awd, wd);
    wait_b(dly);
  endtask

  task automatic check_reset_outputs();
    chk("rst_awready", cw_t'(awready), '0);
    chk("rst_wready", cw_t'(wready), '0);
    chk("rst_arready", cw_t'(arready), '0);
    chk("rst_bvalid", cw_t'(bvalid), '0);
    chk("rst_bresp", cw_t'(bresp), '0);
    chk("rst_rvalid", cw_t'(rvalid), '0);
    chk("rst_rresp", cw_t'(rresp), '0);
    chk("rst_rdata", cw_t'(rdata), '0);
    chk("rst_ctrl_regs", ctrl_regs, '0);
    chk("rst_pulse", cw_t'(ctrl_wr_pulse), '0);
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("awready_before_edge", cw_t'(awready), '0);
    chk("arready_before_edge", cw_t'(arready), '0);
    @(negedge clk);
    chk("awready_after_edge", cw_t'(awready), cw_t'(1'b1));
    chk("wready_after_edge", cw_t'(wready), cw_t'(1'b1));
    chk("arready_after_edge", cw_t'(arready), cw_t'(1'b1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    fail_now("watchdog");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NRW; k++) mdl[k] = '0;
    for (int j = 0; j < NRO; j++) stat[j] = $urandom();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    reset_release();

    for (int i = 0; i < 4; i++) wr(8'(i*4), 32'(i+1), 4'hF, 0, 0, i);
    for (int i = 0; i < 4; i++) rd(8'(i*4), i);

    wr(8'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    wr(8'h08, 32'h11223344, 4'b0101, 0, 0, 1);
    rd(8'h08, 0);
    rd(8'h0B, 1);
    wr(8'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    rd(8'h0C, 0);

    wr(8'h14, 32'h13572468, 4'hF, 0, 3, 1);
    wr(8'h18, 32'h24681357, 4'hF, 3, 0, 2);
    rd(8'h14, 0);
    rd(8'h18, 0);

    stat[0] = 32'hDEADBEEF;
    rd(8'h30, 0);
    wr(8'h30, 32'h12345678, 4'hF, 0, 0, 0);
    rd(8'h3C, 1);
    wr(8'h40, 32'h87654321, 4'hF, 1, 0, 0);
    rd(8'h40, 0);
    rd(8'hFC, 2);

    rd_expect(8'h04);
    fork
      rd_drive(8'h04);
      wr_issue(8'h04, 32'h5A5A5A5A, 4'hF, 0, 0);
    join
    wait_b(0);
    wait_r(0);

    wr_issue(8'h1C, 32'hC0FFEE00, 4'hF, 0, 0);
    rd_expect(8'h00);
    rd_drive(8'h00);
    awaddr = 8'h20; wdata = 32'h0BADF00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 8'h24; arvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_bvalid", cw_t'(bvalid), cw_t'(1'b1));
      chk("bp_bresp", cw_t'(bresp), cw_t'(bq[0].resp));
      chk("bp_rvalid", cw_t'(rvalid), cw_t'(1'b1));
      chk("bp_rdata", cw_t'(rdata), cw_t'(rq[0].dat));
      chk("bp_readies", cw_t'({awready, wready, arready}), '0);
      @(posedge clk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    wait_b(0);
    wait_r(1);
    rd(8'h20, 0);

    for (int i = 0; i < 200; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(64, 255));
      if ($urandom_range(0, 1) == 1) begin
        wr(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3));
      end else begin
        rd(a, $urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) stat[$urandom_range(0, NRO-1)] = $urandom();
    end

    wr(8'h00, 32'hCAFE0001, 4'hF, 0, 0, 0);
    rd_expect(8'h04);
    rd_drive(8'h04);
    awaddr = 8'h00; awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("have_aw_wready", cw_t'(wready), cw_t'(1'b1));
    chk("have_aw_awready", cw_t'(awready), '0);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    for (int k = 0; k < NRW; k++) mdl[k] = '0;
    bq.delete(); rq.delete(); pq.delete();
    b_issued = b_seen; r_issued = r_seen;
    reset_release();
    rd(8'h00, 0);
    chk("post_reset_regs", ctrl_regs, pack_mdl());

    repeat (3) @(posedge clk);
    chk("pulses_outstanding", cw_t'(pq.size()), '0);
    chk("b_outstanding", cw_t'(bq.size()), '0);
    chk("r_outstanding", cw_t'(rq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
